// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state type and default operand width.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } div_state_e;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: trial-subtract the divisor from the partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   partial_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH-1:0] diff;

    // When the subtraction succeeds the result is below the divisor, so WIDTH bits suffice.
    always_comb begin
        qbit_o = (partial_i >= {1'b0, divisor_i});
        diff   = partial_i[WIDTH-1:0] - divisor_i;
        rem_o  = qbit_o ? diff : partial_i[WIDTH-1:0];
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for EX: one quotient bit per cycle, signed/unsigned, divide-by-zero flag, annul.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 dbz_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_e state_q, state_d;

    logic [2*WIDTH:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign1_q, sign1_d, sign2_q, sign2_d;
    logic               sgn_q, sgn_d, dbz_q, dbz_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   abs1, abs2, step_rem, q_raw, q_fix, r_fix;
    logic               step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_i (sh_q[2*WIDTH:WIDTH]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_q)
    );

    // Shift register holds the pre-shifted partial remainder on top, so the step reads it directly.
    always_comb begin
        abs1  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        q_raw = {sh_q[WIDTH-2:0], step_q};
        q_fix = (sgn_q && (sign1_q ^ sign2_q)) ? -q_raw : q_raw;
        r_fix = (sgn_q && sign1_q) ? -step_rem : step_rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (annul_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (start_i) state_d = (opdata2_i == '0) ? S_DIVZERO : S_ON;
                S_DIVZERO: state_d = S_END;
                S_ON:      if (cnt_q == CNT_LAST) state_d = S_END;
                S_END:     if (!start_i) state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sh_d     = sh_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        sgn_d    = sgn_q;
        dbz_d    = dbz_q;
        result_d = result_q;
        if (annul_i) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    sh_d     = {{WIDTH{1'b0}}, abs1, 1'b0};
                    dvs_d    = abs2;
                    cnt_d    = '0;
                    sign1_d  = opdata1_i[WIDTH-1];
                    sign2_d  = opdata2_i[WIDTH-1];
                    sgn_d    = signed_div_i;
                    dbz_d    = (opdata2_i == '0);
                    result_d = '0;
                end
                S_DIVZERO: result_d = '0;
                S_ON: begin
                    sh_d = {step_rem, sh_q[WIDTH-1:0], step_q};
                    if (cnt_q == CNT_LAST) result_d = {r_fix, q_fix};
                    else                   cnt_d    = cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q     <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            sgn_q    <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            sh_q     <= sh_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            sgn_q    <= sgn_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        ready_o  = (state_q == S_END);
        busy_o   = (state_q == S_DIVZERO) || (state_q == S_ON);
        result_o = ready_o ? result_q : '0;
        dbz_o    = ready_o & dbz_q;
    end

endmodule
